// File: rtl/difficulty_selector_pkg.sv
// Shared definitions for the difficulty selector: difficulty codes, controller
// state encoding and button indices used by the top level and the bench.
package diff_sel_pkg;

    localparam int DIFF_W = 32;

    localparam logic [1:0] DIFF_NONE = 2'd0;
    localparam logic [1:0] DIFF_EASY = 2'd1;
    localparam logic [1:0] DIFF_MED  = 2'd2;
    localparam logic [1:0] DIFF_HARD = 2'd3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Index order doubles as event priority: lower index wins
    localparam int BTN_D   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_C   = 2;
    localparam int BTN_R   = 3;
    localparam int NUM_BTN = 4;

endpackage

// File: rtl/difficulty_selector_if.sv
// Handshake bundle between the difficulty selector (master) and the CPU (slave).
interface difficulty_selector_if;

    logic                            diff_ack;
    logic [diff_sel_pkg::DIFF_W-1:0] difficulty;
    logic                            diff_valid;

    modport master (
        output difficulty,
        output diff_valid,
        input  diff_ack
    );

    modport slave (
        input  difficulty,
        input  diff_valid,
        output diff_ack
    );

endinterface

// File: rtl/difficulty_selector_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, optional debounce counter and rise detector
// for one raw button. Counter built only when DIFF_SEL_DEBOUNCE_EN is defined.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic anti_reset,
    input  logic i_btn,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_deb_prev;
    logic r_started;
    logic r_armed;
    logic w_deb;

    if (DEBOUNCE_CYCLES < 2 || (64'(DEBOUNCE_CYCLES) >> CNT_W) != 64'd0) begin : g_param_chk
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DIFF_SEL_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] FLIP_AT = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;

    // The flip edge also requires the first sync stage to disagree, so the level
    // changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt >= FLIP_AT && r_sync1 != r_deb) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_deb = r_deb;
`else
    assign w_deb = r_sync2;
`endif

    // A button held across reset release must be seen released before it can fire
    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            r_started  <= 1'b0;
            r_armed    <= 1'b0;
            r_deb_prev <= 1'b0;
        end else begin
            r_started  <= 1'b1;
            r_deb_prev <= w_deb;
            if (r_started && !r_sync1) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = w_deb & ~r_deb_prev & r_armed;

endmodule

// File: rtl/difficulty_selector.sv
// difficulty_selector: debounced, sticky difficulty latch with a valid/ack handshake.
// Build option DIFF_SEL_DEBOUNCE_EN enables the per-button debounce counters.
module difficulty_selector
    import diff_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                  clock,
    input  logic                  anti_reset,
    input  logic                  btn_l,
    input  logic                  btn_c,
    input  logic                  btn_r,
    input  logic                  btn_d,
    input  logic                  lock,
    difficulty_selector_if.master cpu
);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_rise;
    logic               w_evt;
    logic [1:0]         w_evt_code;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_code;
    logic [1:0]         w_code_nxt;

    always_comb begin
        w_raw        = '0;
        w_raw[BTN_D] = btn_d;
        w_raw[BTN_L] = btn_l;
        w_raw[BTN_C] = btn_c;
        w_raw[BTN_R] = btn_r;
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn (
            .clock      (clock),
            .anti_reset (anti_reset),
            .i_btn      (w_raw[g]),
            .o_rise     (w_rise[g])
        );
    end

    // One event per cycle; lock drops rises outright rather than deferring them
    always_comb begin
        w_evt      = 1'b0;
        w_evt_code = DIFF_NONE;
        if (!lock) begin
            if (w_rise[BTN_D]) begin
                w_evt      = 1'b1;
                w_evt_code = DIFF_NONE;
            end else if (w_rise[BTN_L]) begin
                w_evt      = 1'b1;
                w_evt_code = DIFF_EASY;
            end else if (w_rise[BTN_C]) begin
                w_evt      = 1'b1;
                w_evt_code = DIFF_MED;
            end else if (w_rise[BTN_R]) begin
                w_evt      = 1'b1;
                w_evt_code = DIFF_HARD;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        case (r_state)
            ST_IDLE: begin
                if (w_evt) begin
                    w_state_nxt = ST_PENDING;
                    w_code_nxt  = w_evt_code;
                end
            end
            ST_PENDING: begin
                if (w_evt) begin
                    w_code_nxt = w_evt_code;
                end else if (cpu.diff_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            r_state <= ST_IDLE;
            r_code  <= DIFF_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign cpu.difficulty = {{(DIFF_W-2){1'b0}}, r_code};
    assign cpu.diff_valid = (r_state == ST_PENDING);

endmodule

// File: tb/tb_difficulty_selector.sv
// Bench for difficulty_selector: directed scenarios plus randomized button activity,
// all compared cycle by cycle against a sample-window reference model.
module tb_difficulty_selector;
    import diff_sel_pkg::*;

    localparam int D  = 4;
    localparam int CW = 4;
`ifdef DIFF_SEL_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
    localparam int LAT    = D + 2;
`else
    localparam bit DEB_ON = 1'b0;
    localparam int LAT    = 3;
`endif

    logic clock      = 1'b0;
    logic anti_reset = 1'b0;
    logic btn_l      = 1'b0;
    logic btn_c      = 1'b0;
    logic btn_r      = 1'b0;
    logic btn_d      = 1'b0;
    logic lock       = 1'b0;

    difficulty_selector_if bus();

    difficulty_selector #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .clock      (clock),
        .anti_reset (anti_reset),
        .btn_l      (btn_l),
        .btn_c      (btn_c),
        .btn_r      (btn_r),
        .btn_d      (btn_d),
        .lock       (lock),
        .cpu        (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: raw samples per button (bit 0 = latest), levels and the latch
    logic [15:0] m_hist [4];
    bit          m_deb  [4];
    bit          m_prev [4];
    bit          m_armed[4];
    int          m_n;
    logic [1:0]  m_code;
    bit          m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_hist[i]  = '0;
            m_deb[i]   = 1'b0;
            m_prev[i]  = 1'b0;
            m_armed[i] = 1'b0;
        end
        m_n     = 0;
        m_code  = 2'd0;
        m_valid = 1'b0;
    endtask

    // Level becomes v once the last D samples all equal v; a rise fires only if the
    // button has been seen released since reset; index order is the priority order.
    task automatic model_edge();
        logic [3:0]  raw;
        logic [15:0] mask;
        logic [15:0] win;
        bit          nd;
        bit          found;
        raw   = {btn_r, btn_c, btn_l, btn_d};
        mask  = (16'd1 << D) - 16'd1;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && !lock && m_deb[i] && !m_prev[i] && m_armed[i]) begin
                found  = 1'b1;
                m_code = 2'(i);
            end
        end
        if (found) m_valid = 1'b1;
        else if (bus.diff_ack) m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            win = m_hist[i] & mask;
            if (DEB_ON) begin
                if (win == mask) nd = 1'b1;
                else if (win == 16'd0) nd = 1'b0;
                else nd = m_deb[i];
            end else begin
                nd = m_hist[i][0];
            end
            if (m_n >= 1 && !m_hist[i][0]) m_armed[i] = 1'b1;
            m_prev[i] = m_deb[i];
            m_deb[i]  = nd;
            m_hist[i] = {m_hist[i][14:0], raw[i]};
        end
        m_n++;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!anti_reset) model_clear();
        else model_edge();
        #1;
        chk("difficulty_model", bus.difficulty, {30'd0, m_code});
        chk("diff_valid_model", 32'(bus.diff_valid), 32'(m_valid));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int len;
        bus.diff_ack = 1'b0;
        model_clear();

        // Reset state
        ticks(3);
        chk("reset_difficulty", bus.difficulty, 32'd0);
        chk("reset_valid", 32'(bus.diff_valid), 32'd0);
        anti_reset = 1'b1;
        ticks(4);

        // Medium press: outputs appear exactly LAT edges after the press
        btn_c = 1'b1;
        ticks(LAT - 1);
        chk("c_before_latency", 32'(bus.diff_valid), 32'd0);
        tick();
        chk("c_difficulty", bus.difficulty, 32'd2);
        chk("c_valid", 32'(bus.diff_valid), 32'd1);
        ticks(10 - LAT);
        btn_c = 1'b0;
        ticks(10);
        chk("c_sticky", bus.difficulty, 32'd2);

        // Ack clears valid in one cycle; second ack is a no-op
        bus.diff_ack = 1'b1;
        tick();
        bus.diff_ack = 1'b0;
        chk("ack_valid", 32'(bus.diff_valid), 32'd0);
        chk("ack_difficulty", bus.difficulty, 32'd2);
        bus.diff_ack = 1'b1;
        tick();
        bus.diff_ack = 1'b0;
        ticks(2);
        chk("ack2_valid", 32'(bus.diff_valid), 32'd0);
        chk("ack2_difficulty", bus.difficulty, 32'd2);

        // Short glitch on R
        btn_r = 1'b1;
        ticks(3);
        btn_r = 1'b0;
        ticks(10);
`ifdef DIFF_SEL_DEBOUNCE_EN
        chk("glitch_difficulty", bus.difficulty, 32'd2);
        chk("glitch_valid", 32'(bus.diff_valid), 32'd0);
`endif
        bus.diff_ack = 1'b1;
        tick();
        bus.diff_ack = 1'b0;

        // L and R on the same edge: L wins
        btn_l = 1'b1;
        btn_r = 1'b1;
        ticks(LAT);
        chk("lr_difficulty", bus.difficulty, 32'd1);
        chk("lr_valid", 32'(bus.diff_valid), 32'd1);
        btn_l = 1'b0;
        btn_r = 1'b0;
        ticks(10);
        bus.diff_ack = 1'b1;
        tick();
        bus.diff_ack = 1'b0;

        // Lock discards the R press, even after lock drops while held
        lock  = 1'b1;
        btn_r = 1'b1;
        ticks(12);
        chk("lock_difficulty", bus.difficulty, 32'd1);
        chk("lock_valid", 32'(bus.diff_valid), 32'd0);
        lock = 1'b0;
        ticks(12);
        chk("unlock_held_difficulty", bus.difficulty, 32'd1);
        chk("unlock_held_valid", 32'(bus.diff_valid), 32'd0);
        btn_r = 1'b0;
        ticks(10);
        btn_r = 1'b1;
        ticks(LAT);
        chk("repress_difficulty", bus.difficulty, 32'd3);
        chk("repress_valid", 32'(bus.diff_valid), 32'd1);
        btn_r = 1'b0;
        ticks(10);

        // Overwrite while pending, then D event coincident with ack
        btn_l = 1'b1;
        ticks(LAT);
        chk("overwrite_difficulty", bus.difficulty, 32'd1);
        chk("overwrite_valid", 32'(bus.diff_valid), 32'd1);
        btn_l = 1'b0;
        ticks(10);
        btn_d = 1'b1;
        ticks(LAT - 1);
        bus.diff_ack = 1'b1;
        tick();
        bus.diff_ack = 1'b0;
        chk("clear_ack_difficulty", bus.difficulty, 32'd0);
        chk("clear_ack_valid", 32'(bus.diff_valid), 32'd1);
        btn_d = 1'b0;
        ticks(10);
        bus.diff_ack = 1'b1;
        tick();
        bus.diff_ack = 1'b0;

        // Asynchronous reset while pending and mid-debounce
        btn_l = 1'b1;
        ticks(LAT);
        chk("pre_reset_valid", 32'(bus.diff_valid), 32'd1);
        btn_c = 1'b1;
        ticks(2);
        anti_reset = 1'b0;
        #2;
        model_clear();
        chk("async_reset_difficulty", bus.difficulty, 32'd0);
        chk("async_reset_valid", 32'(bus.diff_valid), 32'd0);
        ticks(3);
        anti_reset = 1'b1;
        ticks(20);
        chk("held_after_reset_difficulty", bus.difficulty, 32'd0);
        chk("held_after_reset_valid", 32'(bus.diff_valid), 32'd0);
        btn_l = 1'b0;
        btn_c = 1'b0;
        ticks(10);
        chk("release_after_reset_valid", 32'(bus.diff_valid), 32'd0);
        btn_c = 1'b1;
        ticks(LAT);
        chk("fresh_press_difficulty", bus.difficulty, 32'd2);
        chk("fresh_press_valid", 32'(bus.diff_valid), 32'd1);
        btn_c = 1'b0;
        ticks(10);

        // Randomized activity against the model
        for (int s = 0; s < 80; s++) begin
            btn_d = ($urandom_range(0, 7) == 0);
            btn_l = ($urandom_range(0, 3) == 0);
            btn_c = ($urandom_range(0, 3) == 0);
            btn_r = ($urandom_range(0, 3) == 0);
            lock  = ($urandom_range(0, 5) == 0);
            len   = int'($urandom_range(1, 10));
            for (int c = 0; c < len; c++) begin
                bus.diff_ack = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        bus.diff_ack = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/difficulty_selector.md
# difficulty_selector

Debounced, sticky difficulty selector that configures the processor's difficulty input from the board buttons. It replaces the per-cycle button decode, where difficulty is non-zero only while a button is held, with a latched value and a valid/ack handshake. Each press is delivered to the CPU exactly once, and the value persists after release. It sits between the board buttons and the processor's `difficulty_in`, clocked by the 50 MHz CPU `clock`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock`, in, 1: single clock for the block.
- `anti_reset`, in, 1: asynchronous, active-low reset.
- `btn_l`, in, 1: raw button, selects easy (code 1).
- `btn_c`, in, 1: raw button, selects medium (code 2).
- `btn_r`, in, 1: raw button, selects hard (code 3).
- `btn_d`, in, 1: raw button, clears the selection (code 0).
- `lock`, in, 1: when high, new selections and clears are ignored (game in progress).
- `diff_ack`, in, 1: CPU consumed the current value; sampled on `clock`.
- `difficulty`, out, 32: latched code, zero-extended from 2 bits.
- `diff_valid`, out, 1: an unconsumed value is pending.

## Operation
- Each raw button passes through a 2-flop synchronizer; synchronizer flops reset to 0.
- Debounce, per button:
  - The debounced level `deb` changes only after the synchronized input differs from `deb` for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle where they agree resets the counter to 0.
  - `deb` resets to 0.
- Event detect: a rise is `deb` going 0→1 (registered previous level). Releases generate no event.
- Event priority within one cycle: D (clear) > L > C > R. At most one event is applied per cycle; lower-priority events that rise in the same cycle are discarded.
- While `lock` = 1, events are discarded and not queued. A button held through `lock` falling does not fire, because its rise already occurred.
- Controller FSM, 2 states:
  - IDLE (`diff_valid` = 0) → PENDING on an accepted event.
  - PENDING (`diff_valid` = 1) → IDLE on `diff_ack`, unless an accepted event occurs in the same cycle.
- Accepted event in any state: load `difficulty` with the event code and enter or stay in PENDING.
- A new event in PENDING overwrites the value; `diff_valid` stays high and the older value is lost.
- Simultaneous `diff_ack` and event: the new value is loaded and `diff_valid` stays 1.
- `diff_ack` in IDLE: ignored.
- `difficulty` is held indefinitely after release and after ack. Only a D event or reset returns it to 0.
- Reset mid-debounce or mid-PENDING: all counters, levels and the FSM return to reset values immediately; no event fires after reset release until a fresh stable press.

## Timing
- Reset values: `difficulty` = 0, `diff_valid` = 0, FSM = IDLE, all counters = 0.
- Latency: raw input stable from edge k gives synchronized input at edge k+2 and `deb` rise at edge k+1+DEBOUNCE_CYCLES. Both `difficulty` and `diff_valid` update at edge k+2+DEBOUNCE_CYCLES.
- `diff_ack` high at edge n gives `diff_valid` = 0 after edge n, so ack-to-clear is 1 cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.
- Counter saturates at `DEBOUNCE_CYCLES`; there is no wrap-around.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DIFF_SEL_DEBOUNCE_EN` defined: per-button debounce counters as above.
- `DIFF_SEL_DEBOUNCE_EN` undefined:
  - `deb` = synchronized input directly; counters are not built and `DEBOUNCE_CYCLES` is ignored.
  - Latency is raw stable at edge k to outputs at edge k+3.
  - Intended for fast simulation.

## Structure
- Package `diff_sel_pkg` holds:
  - codes `DIFF_NONE` = 0, `DIFF_EASY` = 1, `DIFF_MED` = 2, `DIFF_HARD` = 3;
  - FSM state encoding `ST_IDLE` / `ST_PENDING`;
  - the button-index constants.
- Sub-module `btn_debounce` contains the synchronizer, counter and `deb` register, plus its own rise pulse output. It is instantiated 4 times; the macro guard lives inside it.
- The top level holds the priority encoder, the lock gating and the FSM with the `difficulty` register.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4 with the macro defined.
- Reset, then `btn_c` held 10 cycles → `difficulty` = 2 and `diff_valid` = 1 exactly 6 edges after the press. After release, `difficulty` stays 2.
- `diff_valid` = 1, pulse `diff_ack` for 1 cycle → `diff_valid` = 0 next edge, `difficulty` still 2. A second ack has no effect.
- `btn_r` glitch of 3 cycles → no change. `btn_l` and `btn_r` pressed on the same edge → `difficulty` = 1.
- `lock` = 1 during a `btn_r` press → no change. Drop `lock` while still held → still no change. Release and re-press → `difficulty` = 3.
- PENDING with value 1, then a `btn_d` event coincident with `diff_ack` → `difficulty` = 0 and `diff_valid` stays 1.
- Assert `anti_reset` = 0 mid-debounce and while PENDING → outputs 0 immediately (asynchronous). No event after release while the button stays held.
